// File: rtl/se2pa_param.sv
// Serial-to-parallel packer for complex samples: gathers LANES consecutive valid
// samples after a START alignment strobe and presents them as one wide word.
module se2pa_param #(
    parameter int NB      = 16,
    parameter int LANES   = 4,
    parameter int REVERSE = 0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                START,
    input  logic                DV,
    input  logic [NB-1:0]       DR,
    input  logic [NB-1:0]       DI,
    output logic [NB*LANES-1:0] OR,
    output logic [NB*LANES-1:0] OI,
    output logic                RDY,
    output logic                DROP
);

    localparam int CW = $clog2(LANES);
    localparam int W  = NB * LANES;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    localparam logic [CW-1:0] LAST = CW'(LANES - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [NB-1:0] lane_r [LANES];
    logic [NB-1:0] lane_i [LANES];
    logic [W-1:0]  word_r;
    logic [W-1:0]  word_i;
    logic          accept;
    logic          complete;
    logic          discard;

    function automatic int bitrev(input int k);
        int r;
        r = 0;
        for (int b = 0; b < CW; b++) begin
            r[CW-1-b] = k[b];
        end
        return r;
    endfunction

    // Output slot of lane k; slot 0 is the most significant field of the word.
    function automatic int slot_of(input int k);
        return (REVERSE != 0) ? bitrev(k) : k;
    endfunction

    assign accept   = (state == FILL) && DV && !START;
    assign complete = accept && (cnt == LAST);
    assign discard  = START && (state == FILL) && (cnt != '0);

    // The final lane comes straight from the input so the word loads on the accepting edge.
    always_comb begin
        word_r = '0;
        word_i = '0;
        for (int k = 0; k < LANES; k++) begin
            word_r[NB*(LANES-1-slot_of(k)) +: NB] = (k == LANES - 1) ? DR : lane_r[k];
            word_i[NB*(LANES-1-slot_of(k)) +: NB] = (k == LANES - 1) ? DI : lane_i[k];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            RDY   <= 1'b0;
            DROP  <= 1'b0;
        end else begin
            RDY  <= complete;
            DROP <= discard;
            if (START) begin
                state <= FILL;
                cnt   <= DV ? ONE : '0;
            end else if (accept) begin
                cnt <= complete ? '0 : cnt + ONE;
            end
        end
    end

    // START always takes precedence: a coincident sample restarts the group at lane 0.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < LANES; k++) begin
                lane_r[k] <= '0;
                lane_i[k] <= '0;
            end
        end else if (START && DV) begin
            lane_r[0] <= DR;
            lane_i[0] <= DI;
        end else if (accept) begin
            lane_r[cnt] <= DR;
            lane_i[cnt] <= DI;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OR <= '0;
            OI <= '0;
        end else if (complete) begin
            OR <= word_r;
            OI <= word_i;
        end
    end

endmodule

// File: tb/tb_se2pa_param.sv
// Bench for se2pa_param: natural and bit-reversed instances share stimulus and are
// checked by a queue-based scoreboard fed from a group-level reference model.
module tb_se2pa_param;

    localparam int NB    = 16;
    localparam int LANES = 4;
    localparam int W     = NB * LANES;
    localparam int LB    = $clog2(LANES);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          dv = 1'b0;
    logic [NB-1:0] dr = '0;
    logic [NB-1:0] di = '0;
    logic [W-1:0]  or0, oi0, or1, oi1;
    logic          rdy0, rdy1, drop0, drop1;

    always #5 clk = ~clk;

    se2pa_param #(.NB(NB), .LANES(LANES), .REVERSE(0)) dut0 (
        .CLK(clk), .RST(rst), .START(start), .DV(dv), .DR(dr), .DI(di),
        .OR(or0), .OI(oi0), .RDY(rdy0), .DROP(drop0)
    );

    se2pa_param #(.NB(NB), .LANES(LANES), .REVERSE(1)) dut1 (
        .CLK(clk), .RST(rst), .START(start), .DV(dv), .DR(dr), .DI(di),
        .OR(or1), .OI(oi1), .RDY(rdy1), .DROP(drop1)
    );

    typedef struct {
        logic [W-1:0] r0;
        logic [W-1:0] i0;
        logic [W-1:0] r1;
        logic [W-1:0] i1;
        int           cyc;
    } grp_t;

    grp_t          exp_q[$];
    int            drop_q[$];
    logic [NB-1:0] sr_q[$];
    logic [NB-1:0] si_q[$];
    bit            aligned = 1'b0;
    logic [W-1:0]  h_r0 = '0, h_i0 = '0, h_r1 = '0, h_i1 = '0;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic int brev(input int k);
        int r = 0;
        for (int b = 0; b < LB; b++)
            if (((k >> b) & 1) != 0) r = r | (1 << (LB - 1 - b));
        return r;
    endfunction

    // Slot s (0 = most significant) carries lane s, or lane brev(s) when reversed.
    function automatic logic [W-1:0] pack(input logic [NB-1:0] s[$], input bit rev);
        logic [W-1:0] w = '0;
        for (int slot = 0; slot < LANES; slot++)
            w = (w << NB) | W'(s[rev ? brev(slot) : slot]);
        return w;
    endfunction

    task automatic model(input bit st, input bit v, input logic [NB-1:0] r, input logic [NB-1:0] i);
        grp_t g;
        if (st) begin
            if (aligned && sr_q.size() > 0) drop_q.push_back(cyc + 1);
            sr_q.delete();
            si_q.delete();
            aligned = 1'b1;
            if (v) begin
                sr_q.push_back(r);
                si_q.push_back(i);
            end
        end else if (aligned && v) begin
            sr_q.push_back(r);
            si_q.push_back(i);
            if (sr_q.size() == LANES) begin
                g.r0 = pack(sr_q, 1'b0);
                g.i0 = pack(si_q, 1'b0);
                g.r1 = pack(sr_q, 1'b1);
                g.i1 = pack(si_q, 1'b1);
                g.cyc = cyc + 1;
                exp_q.push_back(g);
                h_r0 = g.r0; h_i0 = g.i0; h_r1 = g.r1; h_i1 = g.i1;
                sr_q.delete();
                si_q.delete();
            end
        end
    endtask

    task automatic model_reset();
        aligned = 1'b0;
        sr_q.delete();
        si_q.delete();
        h_r0 = '0; h_i0 = '0; h_r1 = '0; h_i1 = '0;
    endtask

    task automatic cycle(input bit st, input bit v, input logic [NB-1:0] r);
        @(negedge clk);
        #1;
        start = st;
        dv    = v;
        dr    = v ? r : NB'($urandom);
        di    = v ? (r ^ 16'h5a5a) : NB'($urandom);
        model(st, v, dr, di);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, '0);
    endtask

    // Monitor: outputs must hold the model's last group; pulses pop the queues.
    always @(negedge clk) begin
        chk("hold_or0", or0, h_r0);
        chk("hold_oi0", oi0, h_i0);
        chk("hold_or1", or1, h_r1);
        chk("hold_oi1", oi1, h_i1);
        if (rdy0 || rdy1) begin
            chk("rdy_pair", W'(rdy0), W'(rdy1));
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rdy_unexpected actual=1 required=0 at t=%0t", $time);
            end else begin
                grp_t g;
                g = exp_q.pop_front();
                chk("rdy_cycle", W'(cyc), W'(g.cyc));
                chk("grp_or0", or0, g.r0);
                chk("grp_oi0", oi0, g.i0);
                chk("grp_or1", or1, g.r1);
                chk("grp_oi1", oi1, g.i1);
            end
        end
        if (drop0 || drop1) begin
            chk("drop_pair", W'(drop0), W'(drop1));
            if (drop_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL drop_unexpected actual=1 required=0 at t=%0t", $time);
            end else begin
                chk("drop_cycle", W'(cyc), W'(drop_q.pop_front()));
            end
        end
    end

    initial begin
        #1;
        chk("reset_or", or0, '0);
        chk("reset_rdy", W'(rdy0), '0);
        chk("reset_drop", W'(drop0), '0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        // Samples before any START are ignored.
        cycle(1'b0, 1'b1, 16'h00ee);
        cycle(1'b0, 1'b1, 16'h00ef);
        idle(1);

        cycle(1'b1, 1'b1, 16'h0001);
        cycle(1'b0, 1'b1, 16'h0002);
        cycle(1'b0, 1'b1, 16'h0003);
        cycle(1'b0, 1'b1, 16'h0004);
        idle(1);
        chk("basic_nat", or0, 64'h0001_0002_0003_0004);
        chk("basic_rev", or1, 64'h0001_0003_0002_0004);

        // Gapped input; START at CNT=0 only realigns.
        cycle(1'b1, 1'b0, '0);
        cycle(1'b0, 1'b1, 16'h00a0);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 16'h00b0);
        cycle(1'b0, 1'b1, 16'h00c0);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 16'h00d0);
        idle(1);
        chk("gaps_nat", or0, 64'h00a0_00b0_00c0_00d0);

        // Restart after two samples, then at CNT=LANES-1.
        cycle(1'b1, 1'b1, 16'h0005);
        cycle(1'b0, 1'b1, 16'h0006);
        cycle(1'b1, 1'b1, 16'h0009);
        cycle(1'b0, 1'b1, 16'h000a);
        cycle(1'b0, 1'b1, 16'h000b);
        cycle(1'b1, 1'b1, 16'h0011);
        cycle(1'b0, 1'b1, 16'h0012);
        cycle(1'b0, 1'b1, 16'h0013);
        cycle(1'b0, 1'b1, 16'h0014);
        idle(1);
        chk("drop_last_nat", or0, 64'h0011_0012_0013_0014);

        cycle(1'b1, 1'b1, 16'h0009);
        for (int k = 1; k < 12; k++) cycle(1'b0, 1'b1, NB'(16'h0100 + k));
        idle(1);
        chk("stream_last", or0, 64'h0108_0109_010a_010b);

        for (int n = 0; n < 400; n++)
            cycle($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, NB'($urandom));
        idle(2);

        // Asynchronous reset in the middle of a group.
        cycle(1'b1, 1'b1, 16'h0021);
        cycle(1'b0, 1'b1, 16'h0022);
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_or0", or0, '0);
        chk("arst_oi1", oi1, '0);
        chk("arst_rdy", W'(rdy0), '0);
        chk("arst_drop", W'(drop0), '0);
        @(negedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1, NB'(16'h0030 + k));
        idle(3);

        chk("exp_q_empty", W'(exp_q.size()), '0);
        chk("drop_q_empty", W'(drop_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/se2pa_param.md
SE2PA_PARAM -- requirements
Module: se2pa_param

Interface
REQ-001 Parameter NB, default 16: sample width in bits, per real and per imaginary part; legal range 4..32.
REQ-002 Parameter LANES, default 4: samples per parallel output word; power of two, legal range 2..16.
REQ-003 Parameter REVERSE, default 0: 0 = natural lane order; 1 = bit-reversed lane order.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST  input  1  reset, asynchronous and active-high.
REQ-006 START  input  1  frame-align strobe; the next sample to be accepted becomes lane 0.
REQ-007 DV  input  1  input sample valid.
REQ-008 DR  input  NB  real part of the serial sample.
REQ-009 DI  input  NB  imaginary part of the serial sample.
REQ-010 OR  output  NB*LANES  parallel real word (registered).
REQ-011 OI  output  NB*LANES  parallel imaginary word (registered).
REQ-012 RDY  output  1  one-cycle pulse: OR/OI hold a newly completed group.
REQ-013 DROP  output  1  one-cycle pulse: a partially filled group was discarded.

Function
REQ-014 States: IDLE (no alignment yet, samples ignored) and FILL (accumulating); lane counter CNT is log2(LANES) bits.
REQ-015 IDLE -> FILL on any cycle with START=1; if DV=1 in that cycle, the sample is stored as lane 0 and CNT becomes 1, else CNT becomes 0.
REQ-016 In IDLE with START=0: DV/DR/DI ignored; RDY and DROP stay 0.
REQ-017 In FILL with START=0 and DV=1: the sample is stored at lane CNT and CNT increments.
REQ-018 In FILL with DV=0 and START=0: CNT and all stored samples hold (gaps allowed, any length).
REQ-019 Sample accepted at CNT=LANES-1: on the same edge OR/OI load all LANES samples (including the current DR/DI), CNT wraps to 0, state stays FILL.
REQ-020 RDY=1 in the cycle after the edge that accepts lane LANES-1, for exactly one cycle; latency from final sample to RDY is 1 clock.
REQ-021 OR/OI change only on group completion; between completions they hold the last group.
REQ-022 Placement, REVERSE=0: lane k occupies OR[NB*(LANES-k)-1 : NB*(LANES-k-1)], so lane 0 is most significant; OI likewise.
REQ-023 Placement, REVERSE=1: lane k occupies the slot that REQ-022 assigns to lane bitrev(k), with bitrev over log2(LANES) bits.
REQ-024 START in FILL with CNT!=0: partial group discarded, DROP=1 next cycle, then REQ-015 applies; OR/OI unchanged; no RDY.
REQ-025 START in FILL with CNT=0: realign only; no DROP.
REQ-026 START coinciding with DV at CNT=LANES-1: START wins; group not completed, DROP=1, no RDY, current sample becomes lane 0.
REQ-027 Back-to-back valid input: RDY pulses exactly every LANES cycles; no sample lost across group boundaries.
REQ-028 No arithmetic on data; samples pass bit-exact.

Reset
REQ-029 While RST=1, regardless of CLK: state=IDLE, CNT=0, OR=0, OI=0, RDY=0, DROP=0, stored lane registers=0.
REQ-030 Reset mid-group discards the partial group with no DROP pulse; after release the block waits in IDLE for START.

Verification
REQ-031 LANES=4: reset, START+DV with DR=1,2,3,4 on consecutive cycles -> RDY one cycle later, OR=0x0001_0002_0003_0004.
REQ-032 REVERSE=1, LANES=4: same stimulus -> OR=0x0001_0003_0002_0004.
REQ-033 DV=1,0,0,1,1,0,1 carrying DR=A,-,-,B,C,-,D after START -> single RDY, OR={A,B,C,D}, no RDY during gaps.
REQ-034 Two samples after START, then START+DV with DR=9 -> DROP pulse, no RDY, OR unchanged; three more samples -> OR={9,...}.
REQ-035 Continuous DV for 12 cycles after START -> RDY at cycles 4, 8 and 12 after the first sample, with three distinct correct groups.
REQ-036 RST asserted asynchronously mid-group -> OR=0 and RDY=0 immediately; DV without START after release -> no RDY.
